instruction_loader: RTL and testbench

Host-side instruction ingest stage that sits directly upstream of the control unit's instruction memory. It receives a byte stream on `ui_in` and assembles pairs of bytes into 16-bit instruction words (3-bit opcode, 13-bit operand). It writes each word to consecutive instruction-memory addresses starting at 0. It reports completion or error so the host can then pulse `start` to the dispatch FSM.

---
 rtl/tpu_pkg.sv | 25 ++
 rtl/instruction_loader.sv | 191 +++++++++++++++++++
 tb/tb_instruction_loader.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU control path: instruction word layout,
// opcode encodings and the instruction-loader state enum.
package tpu_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] NO_OP       = 3'b000;
    localparam logic [OPCODE_W-1:0] LOAD_ADDR   = 3'b001;
    localparam logic [OPCODE_W-1:0] LOAD_WEIGHT = 3'b010;
    localparam logic [OPCODE_W-1:0] LOAD_INPUTS = 3'b011;
    localparam logic [OPCODE_W-1:0] COMPUTE     = 3'b100;
    localparam logic [OPCODE_W-1:0] STORE       = 3'b101;
    localparam logic [OPCODE_W-1:0] EXT         = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        CHK   = 3'd4,
        FIN   = 3'd5
    } loader_state_t;

endpackage

// File: rtl/instruction_loader.sv
// Byte-stream to instruction-memory loader: count byte N, then N 16-bit words high byte first.
// Optional trailing XOR checksum byte is enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instruction_loader
    import tpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_ins,
    input  logic [7:0]          ui_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [INSTR_W-1:0]  wr_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     load_count
);

    localparam int         CNT_W     = ADDR_W + 1;
    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

    loader_state_t     state_r;
    loader_state_t     state_next_s;
    logic              accept_s;
    logic              count_bad_s;
    logic              last_word_s;
    logic [CNT_W-1:0]  idx_r;
    logic [CNT_W-1:0]  idx_inc_s;
    logic [CNT_W-1:0]  n_r;
    logic [7:0]        hi_r;
    logic              in_ready_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [INSTR_W-1:0] wr_data_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [CNT_W-1:0]  load_count_r;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        csum_r;
`endif

    assign accept_s    = in_valid & in_ready_r;
    assign count_bad_s = ({1'b0, ui_in} > DEPTH_LIM);
    assign idx_inc_s   = idx_r + CNT_W'(1);
    assign last_word_s = (idx_inc_s == n_r);

    assign in_ready   = in_ready_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign load_count = load_count_r;

    // Next-state decode; every byte-consuming state holds until a byte is accepted.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (fetch_ins) state_next_s = COUNT;
                else           state_next_s = IDLE;
            end
            COUNT: begin
                if (!accept_s)              state_next_s = COUNT;
                else if (ui_in == 8'd0)     state_next_s = FIN;
                else if (count_bad_s)       state_next_s = IDLE;
                else                        state_next_s = HI;
            end
            HI: begin
                if (accept_s) state_next_s = LO;
                else          state_next_s = HI;
            end
            LO: begin
                if (!accept_s)         state_next_s = LO;
                else if (!last_word_s) state_next_s = HI;
`ifdef INSTR_LOADER_CHECKSUM_EN
                else                   state_next_s = CHK;
`else
                else                   state_next_s = FIN;
`endif
            end
            CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                if (!accept_s)              state_next_s = CHK;
                else if (ui_in == csum_r)   state_next_s = FIN;
                else                        state_next_s = IDLE;
`else
                state_next_s = IDLE;
`endif
            end
            FIN:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Status outputs are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= (state_next_s == COUNT) || (state_next_s == HI) ||
                          (state_next_s == LO)    || (state_next_s == CHK);
            busy_r     <= (state_next_s != IDLE);
            done_r     <= (state_next_s == FIN);
        end
    end

    // Word assembly, write strobe, error and count bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r        <= '0;
            n_r          <= '0;
            hi_r         <= 8'd0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= 16'd0;
            err_r        <= 1'b0;
            load_count_r <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_r       <= 8'd0;
`endif
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fetch_ins) begin
                        err_r        <= 1'b0;
                        load_count_r <= '0;
                        idx_r        <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum_r       <= 8'd0;
`endif
                    end
                end
                COUNT: begin
                    if (accept_s) begin
                        n_r <= CNT_W'(ui_in);
                        if (count_bad_s) err_r <= 1'b1;
                    end
                end
                HI: begin
                    if (accept_s) begin
                        hi_r <= ui_in;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum_r <= csum_r ^ ui_in;
`endif
                    end
                end
                LO: begin
                    if (accept_s) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= idx_r[ADDR_W-1:0];
                        wr_data_r <= {hi_r, ui_in};
                        idx_r     <= idx_inc_s;
                        if (last_word_s) load_count_r <= n_r;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum_r    <= csum_r ^ ui_in;
`endif
                    end
                end
                CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    // A bad checksum keeps load_count at zero; the words stay written.
                    if (accept_s && (ui_in != csum_r)) begin
                        err_r        <= 1'b1;
                        load_count_r <= '0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader (DEPTH=16); checksum tests
// are included when INSTR_LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;

    logic        clk;
    logic        reset;
    logic        fetch_ins;
    logic [7:0]  ui_in;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  load_count;

    int checks = 0;
    int errors = 0;

    logic [3:0]  wa_q[$];
    logic [15:0] wd_q[$];
    int          done_cnt = 0;
    int          both_cnt = 0;
    logic [15:0] stim_w[0:31];

    instruction_loader #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset), .fetch_ins(fetch_ins), .ui_in(ui_in),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .err(err), .load_count(load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record writes and done pulses once per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (done === 1'b1) done_cnt++;
        if (done === 1'b1 && wr_en === 1'b1) both_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        ui_in    = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_fetch();
        fetch_ins = 1'b1;
        @(negedge clk);
        fetch_ins = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    // Stall gap between bytes: in_valid low for one cycle, optionally poking fetch_ins.
    task automatic gap(input bit stall, input bit poke);
        if (stall) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_ready: in_ready=%b required 1", in_ready);
            end
            if (poke) fetch_ins = 1'b1;
            @(negedge clk);
            fetch_ins = 1'b0;
        end
    endtask

    // Full stream from stim_w[0..n-1]; checksum byte appended when enabled and n>0.
    task automatic send_load(input int n, input bit stall, input bit poke);
        logic [7:0] x = 8'h00;
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            gap(stall, poke && (i == 0));
            send_byte(stim_w[i][15:8]);
            x = x ^ stim_w[i][15:8];
            gap(stall, 1'b0);
            send_byte(stim_w[i][7:0]);
            x = x ^ stim_w[i][7:0];
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (n > 0) begin
            gap(stall, 1'b0);
            send_byte(x);
        end
`endif
    endtask

    task automatic test_reset();
        int w0;
        #1;
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err, load_count} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {in_ready, wr_en, wr_addr, wr_data, busy, done, err, load_count});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_fetch();
        send_byte(8'd2);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_hi_state: busy=%b in_ready=%b required 1 1", busy, in_ready);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err, load_count} !== 30'd0) begin
            errors++;
            $display("FAIL async_reset: got %h required 0",
                     {in_ready, wr_en, wr_addr, wr_data, busy, done, err, load_count});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        w0 = wa_q.size();
        done_cnt = done_cnt;
        stim_w[0] = 16'h2005;
        do_fetch();
        send_load(1, 1'b0, 1'b0);
        wait_idle();
        checks++;
        if (wa_q.size() - w0 !== 1) begin
            errors++;
            $display("FAIL post_reset_writes: got %0d required 1", wa_q.size() - w0);
        end else begin
            checks++;
            if (wa_q[w0] !== 4'd0 || wd_q[w0] !== 16'h2005) begin
                errors++;
                $display("FAIL post_reset_word: got %0d/%h required 0/2005", wa_q[w0], wd_q[w0]);
            end
        end
        checks++;
        if (done_cnt !== 1 || load_count !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_done: done=%0d count=%0d required 1 1", done_cnt, load_count);
        end
    endtask

    task automatic test_normal(input bit stall, input bit poke);
        int w0, d0, b0;
        w0 = wa_q.size(); d0 = done_cnt; b0 = both_cnt;
        stim_w[0] = 16'h4000; stim_w[1] = 16'h8000; stim_w[2] = 16'h0000;
        do_fetch();
        send_load(3, stall, poke);
        wait_idle();
        checks++;
        if (wa_q.size() - w0 !== 3) begin
            errors++;
            $display("FAIL normal_writes(stall=%0d): got %0d required 3", stall, wa_q.size() - w0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa_q[w0+i] !== 4'(i) || wd_q[w0+i] !== stim_w[i]) begin
                    errors++;
                    $display("FAIL normal_word%0d(stall=%0d): got %0d/%h required %0d/%h",
                             i, stall, wa_q[w0+i], wd_q[w0+i], i, stim_w[i]);
                end
            end
        end
        checks++;
        if (done_cnt - d0 !== 1 || load_count !== 5'd3 || err !== 1'b0) begin
            errors++;
            $display("FAIL normal_status(stall=%0d): done=%0d count=%0d err=%b required 1 3 0",
                     stall, done_cnt - d0, load_count, err);
        end
`ifndef INSTR_LOADER_CHECKSUM_EN
        checks++;
        if (both_cnt - b0 !== 1) begin
            errors++;
            $display("FAIL done_with_last_write: got %0d required 1", both_cnt - b0);
        end
`endif
    endtask

    task automatic test_zero();
        int w0, d0;
        w0 = wa_q.size(); d0 = done_cnt;
        do_fetch();
        send_load(0, 1'b0, 1'b0);
        wait_idle();
        checks++;
        if (wa_q.size() - w0 !== 0 || done_cnt - d0 !== 1 || load_count !== 5'd0) begin
            errors++;
            $display("FAIL zero_load: writes=%0d done=%0d count=%0d required 0 1 0",
                     wa_q.size() - w0, done_cnt - d0, load_count);
        end
    endtask

    task automatic test_full();
        int w0;
        w0 = wa_q.size();
        for (int i = 0; i < 16; i++) stim_w[i] = {8'(i), 8'(8'hF0 - 8'(i))};
        do_fetch();
        send_load(16, 1'b0, 1'b0);
        wait_idle();
        checks++;
        if (wa_q.size() - w0 !== 16) begin
            errors++;
            $display("FAIL full_writes: got %0d required 16", wa_q.size() - w0);
        end else begin
            checks++;
            if (wa_q[w0+15] !== 4'd15 || wd_q[w0+15] !== 16'h0FE1) begin
                errors++;
                $display("FAIL full_last: got %0d/%h required 15/0fe1", wa_q[w0+15], wd_q[w0+15]);
            end
        end
        checks++;
        if (load_count !== 5'd16) begin
            errors++;
            $display("FAIL full_count: got %0d required 16", load_count);
        end
    endtask

    task automatic test_overflow();
        int w0, d0;
        w0 = wa_q.size(); d0 = done_cnt;
        do_fetch();
        send_byte(8'd17);
        wait_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b1 || wa_q.size() - w0 !== 0 || done_cnt - d0 !== 0 || load_count !== 5'd0) begin
            errors++;
            $display("FAIL overflow: err=%b writes=%0d done=%0d count=%0d required 1 0 0 0",
                     err, wa_q.size() - w0, done_cnt - d0, load_count);
        end
        do_fetch();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err=%b busy=%b required 0 1", err, busy);
        end
        send_byte(8'd0);
        wait_idle();
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int w0, d0;
        w0 = wa_q.size(); d0 = done_cnt;
        do_fetch();
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
        wait_idle();
        checks++;
        if (wa_q.size() - w0 !== 1 || done_cnt - d0 !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL chk_good: writes=%0d done=%0d err=%b required 1 1 0",
                     wa_q.size() - w0, done_cnt - d0, err);
        end else begin
            checks++;
            if (wd_q[w0] !== 16'h1234) begin
                errors++;
                $display("FAIL chk_good_word: got %h required 1234", wd_q[w0]);
            end
        end
        w0 = wa_q.size(); d0 = done_cnt;
        do_fetch();
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
        wait_idle();
        checks++;
        if (wa_q.size() - w0 !== 1 || done_cnt - d0 !== 0 || err !== 1'b1) begin
            errors++;
            $display("FAIL chk_bad: writes=%0d done=%0d err=%b required 1 0 1",
                     wa_q.size() - w0, done_cnt - d0, err);
        end else begin
            checks++;
            if (wd_q[w0] !== 16'h1234) begin
                errors++;
                $display("FAIL chk_bad_word: got %h required 1234", wd_q[w0]);
            end
        end
    endtask
`endif

    initial begin
        reset     = 1'b0;
        fetch_ins = 1'b0;
        ui_in     = 8'h00;
        in_valid  = 1'b0;
        test_reset();
        test_normal(1'b0, 1'b0);
        test_normal(1'b1, 1'b1);
        test_zero();
        test_full();
        test_overflow();
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
